sprite_line_engine: RTL and testbench

Parametrised per-scanline sprite evaluator and pixel generator for the PPU, the successor to the fixed 8-sprite / 16x16 / 2-bpp pixel path. During horizontal blanking it scans the attribute table for the next line and loads up to MAX_SPRITES slots. During active video it emits one priority-resolved colour index per pixel strobe. It adds horizontal flip, a sprite-overflow flag, and a bounded, deterministic evaluation time.

---
 rtl/sprite_line_engine.sv | 213 +++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_engine.sv
// sprite_line_engine: per-scanline sprite evaluator and pixel generator.
// During blanking it scans the attribute table for the requested line and
// loads up to MAX_SPRITES slots; during active video it emits one
// priority-resolved colour index per pixel strobe.
// Optional feature macro: SPRITE_LINE_HFLIP_EN (attribute bit 31 mirrors the
// sprite horizontally; when undefined the bit is ignored and no flip logic exists).
module sprite_line_engine #(
  parameter int MAX_SPRITES = 8,
  parameter int NUM_ATTRS   = 64,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int BPP         = 2,
  parameter int PAL_W       = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         eval_start,
  input  logic [9:0]                   eval_line,
  output logic                         eval_done,
  output logic [$clog2(NUM_ATTRS)-1:0] attr_addr,
  input  logic [31:0]                  attr_data,
  output logic [9:0]                   pat_addr,
  input  logic [31:0]                  pat_data,
  input  logic                         pixel_en,
  input  logic [9:0]                   pixel_x,
  output logic [PAL_W+BPP-1:0]         pix_color,
  output logic                         pix_opaque,
  output logic                         overflow
);

  localparam int AW = $clog2(NUM_ATTRS);
  localparam int SW = $clog2(MAX_SPRITES + 1);
  localparam int CW = $clog2(SPRITE_W);
  localparam int PW = SPRITE_W * BPP;

  typedef enum logic [2:0] {IDLE, A_FETCH, A_CHECK, P_FETCH, P_LOAD, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0] a;
  logic [SW-1:0] s;
  logic [9:0]    line_q;

  logic [MAX_SPRITES-1:0] slot_valid;
  logic [9:0]             slot_x   [MAX_SPRITES];
  logic [PAL_W-1:0]       slot_pal [MAX_SPRITES];
  logic [PW-1:0]          slot_pat [MAX_SPRITES];
`ifdef SPRITE_LINE_HFLIP_EN
  logic                   slot_flip [MAX_SPRITES];
`endif

  // Attribute word fields; the whole input words are folded into a sink so
  // reserved/unused bits do not look like forgotten wiring.
  logic [9:0]       attr_y;
  logic [9:0]       attr_x;
  logic [7:0]       attr_p;
  logic [PAL_W-1:0] attr_pal;
  logic [9:0]       row;
  logic [17:0]      pat_addr_full;
  logic             y_match;
  logic             last_attr;
  logic             slots_full;
  logic             unused_inputs;

  assign attr_y        = attr_data[9:0];
  assign attr_x        = attr_data[19:10];
  assign attr_p        = attr_data[27:20];
  assign attr_pal      = attr_data[27+PAL_W:28];
  assign row           = line_q - attr_y;
  assign y_match       = (line_q >= attr_y) && (row < 10'(SPRITE_H));
  assign pat_addr_full = ({10'b0, attr_p} * 18'(SPRITE_H)) + {8'b0, row};
  assign last_attr     = (a == AW'(NUM_ATTRS - 1));
  assign slots_full    = (s == SW'(MAX_SPRITES));
  assign attr_addr     = a;
  assign unused_inputs = ^{attr_data, pat_data};

  // Control strobes decoded from the current state
  logic start_eval;
  logic take_slot;
  logic set_ovf;
  logic load_pat;
  logic advance;

  // State register; reset aborts any evaluation in progress
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic walking the attribute table one entry at a time
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (eval_start) state_next = A_FETCH;
      A_FETCH: state_next = A_CHECK;
      A_CHECK: begin
        if (y_match)        state_next = slots_full ? DONE : P_FETCH;
        else if (last_attr) state_next = DONE;
        else                state_next = A_FETCH;
      end
      P_FETCH: state_next = P_LOAD;
      P_LOAD:  state_next = last_attr ? DONE : A_FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: datapath strobes for each state
  always_comb begin
    start_eval = (state == IDLE) && eval_start;
    take_slot  = (state == A_CHECK) && y_match && !slots_full;
    set_ovf    = (state == A_CHECK) && y_match && slots_full;
    load_pat   = (state == P_LOAD);
    advance    = ((state == A_CHECK) && !y_match && !last_attr) ||
                 ((state == P_LOAD) && !last_attr);
  end

  // Evaluation counters, overflow flag, done pulse and pattern address
  always_ff @(posedge clk) begin
    if (!reset) begin
      a          <= '0;
      s          <= '0;
      line_q     <= '0;
      slot_valid <= '0;
      overflow   <= 1'b0;
      eval_done  <= 1'b0;
      pat_addr   <= '0;
    end else begin
      eval_done <= (state == DONE);
      if (start_eval) begin
        slot_valid <= '0;
        a          <= '0;
        s          <= '0;
        line_q     <= eval_line;
        if (eval_line == 10'd0) overflow <= 1'b0;
      end
      if (advance)   a        <= a + AW'(1);
      if (set_ovf)   overflow <= 1'b1;
      if (take_slot) pat_addr <= pat_addr_full[9:0];
      if (load_pat) begin
        for (int i = 0; i < MAX_SPRITES; i++)
          if (SW'(i) == s) slot_valid[i] <= 1'b1;
        s <= s + SW'(1);
      end
    end
  end

  // Slot payload storage; contents only matter while the valid bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_SPRITES; i++) begin
      if (take_slot && SW'(i) == s) begin
        slot_x[i]   <= attr_x;
        slot_pal[i] <= attr_pal;
`ifdef SPRITE_LINE_HFLIP_EN
        slot_flip[i] <= attr_data[31];
`endif
      end
      if (load_pat && SW'(i) == s) slot_pat[i] <= pat_data[PW-1:0];
    end
  end

  // Pixel column col of a pattern row; column 0 sits in the top bits
  function automatic logic [BPP-1:0] px_of(input logic [PW-1:0] pat, input logic [CW-1:0] col);
    px_of = '0;
    for (int k = 0; k < SPRITE_W; k++)
      if (col == CW'(k)) px_of = pat[PW-1-k*BPP -: BPP];
  endfunction

  logic [PAL_W+BPP-1:0] hit_color;
  logic                 hit_any;

  // Priority resolve: scan from the highest slot down so the lowest opaque slot wins
  always_comb begin
    logic [9:0]     col_off;
    logic [CW-1:0]  col;
    logic [BPP-1:0] v;
    hit_color = '0;
    hit_any   = 1'b0;
    col_off   = '0;
    col       = '0;
    v         = '0;
    for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
      col_off = pixel_x - slot_x[i];
      col     = col_off[CW-1:0];
`ifdef SPRITE_LINE_HFLIP_EN
      if (slot_flip[i]) col = CW'(SPRITE_W - 1) - col;
`endif
      v = px_of(slot_pat[i], col);
      if (slot_valid[i] && (pixel_x >= slot_x[i]) && (col_off < 10'(SPRITE_W)) && (v != '0)) begin
        hit_color = {slot_pal[i], v};
        hit_any   = 1'b1;
      end
    end
  end

  // Registered pixel output; holds between strobes, transparent while evaluating
  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_color  <= '0;
      pix_opaque <= 1'b0;
    end else if (pixel_en) begin
      if (state != IDLE) begin
        pix_color  <= '0;
        pix_opaque <= 1'b0;
      end else begin
        pix_color  <= hit_color;
        pix_opaque <= hit_any;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed bench for sprite_line_engine with
// synchronous-read attribute and pattern RAM models.
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        evalStart;
  logic [9:0]  evalLine;
  logic        evalDone;
  logic [5:0]  attrAddr;
  logic [31:0] attrData;
  logic [9:0]  patAddr;
  logic [31:0] patData;
  logic        pixelEn;
  logic [9:0]  pixelX;
  logic [4:0]  pixColor;
  logic        pixOpaque;
  logic        overflow;

  logic [31:0] attrMem [64];
  logic [31:0] patMem  [1024];

  int checks   = 0;
  int failures = 0;

  sprite_line_engine dut (
    .clk        (clk),
    .reset      (reset),
    .eval_start (evalStart),
    .eval_line  (evalLine),
    .eval_done  (evalDone),
    .attr_addr  (attrAddr),
    .attr_data  (attrData),
    .pat_addr   (patAddr),
    .pat_data   (patData),
    .pixel_en   (pixelEn),
    .pixel_x    (pixelX),
    .pix_color  (pixColor),
    .pix_opaque (pixOpaque),
    .overflow   (overflow)
  );

  // 100 MHz style free-running clock
  always #5 clk = ~clk;

  // Synchronous-read RAMs: data valid one cycle after the address
  always @(posedge clk) begin
    attrData <= attrMem[attrAddr];
    patData  <= patMem[patAddr];
  end

  function automatic logic [31:0] mkAttr(input int y, input int x, input int p, input int pal, input int flip);
    logic [31:0] w;
    w = {1'(flip), 3'(pal), 8'(p), 10'(x), 10'(y)};
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clearAttrs();
    for (int i = 0; i < 64; i++) attrMem[i] = mkAttr(900, 0, 0, 0, 0);
  endtask

  task automatic startEval(input int line);
    @(negedge clk);
    evalLine  = 10'(line);
    evalStart = 1'b1;
    @(negedge clk);
    evalStart = 1'b0;
  endtask

  // Waits for eval_done (bounded); cycles counts rising edges from the one that took eval_start
  task automatic waitDone(input string tag, output int cycles);
    cycles = 1;
    while (evalDone !== 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_done"}, 32'(evalDone), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(evalDone), 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input int line, input int expCycles);
    int cycles;
    startEval(line);
    waitDone(tag, cycles);
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
  endtask

  task automatic pixelCheck(input string tag, input int x, input int expColor, input int expOpaque);
    @(negedge clk);
    pixelEn = 1'b1;
    pixelX  = 10'(x);
    @(negedge clk);
    pixelEn = 1'b0;
    checkOutput({tag, "_color"}, 32'(pixColor), 32'(expColor));
    checkOutput({tag, "_opaque"}, 32'(pixOpaque), 32'(expOpaque));
  endtask

  initial begin
    int cycles;
    int doneSeen;
    reset     = 1'b0;
    evalStart = 1'b0;
    evalLine  = '0;
    pixelEn   = 1'b0;
    pixelX    = '0;
    clearAttrs();
    for (int i = 0; i < 1024; i++) patMem[i] = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst_done", 32'(evalDone), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_color", 32'(pixColor), 32'd0);
    checkOutput("rst_opaque", 32'(pixOpaque), 32'd0);
    checkOutput("rst_attr_addr", 32'(attrAddr), 32'd0);
    checkOutput("rst_pat_addr", 32'(patAddr), 32'd0);
    reset = 1'b1;

    $display("[TB] single sprite on line 101");
    attrMem[0]  = mkAttr(100, 200, 1, 2, 0);
    patMem[17]  = 32'h4000_0000;
    applyStimulus("t1", 101, 132);
    pixelCheck("t1_x200", 200, 5'b010_01, 1);
    @(negedge clk);
    checkOutput("t1_hold", 32'(pixColor), 32'd9);
    pixelCheck("t1_x199", 199, 0, 0);
    pixelCheck("t1_x216", 216, 0, 0);
    pixelCheck("t1_x201", 201, 0, 0);

    $display("[TB] pixel strobe during evaluation");
    startEval(101);
    repeat (6) @(negedge clk);
    pixelCheck("busy_x200", 200, 0, 0);
    waitDone("busy", cycles);

    $display("[TB] empty line 50");
    applyStimulus("t2", 50, 130);
    pixelCheck("t2_x200", 200, 0, 0);

    $display("[TB] overflow with nine sprites on line 10");
    clearAttrs();
    for (int i = 0; i < 9; i++) attrMem[i] = mkAttr(10, 100 + 20 * i, 2, i % 8, 0);
    patMem[32] = 32'hC000_0000;
    applyStimulus("t3", 10, 36);
    checkOutput("t3_ovf", 32'(overflow), 32'd1);
    pixelCheck("t3_slot0", 100, 5'b000_11, 1);
    pixelCheck("t3_slot7", 240, 5'b111_11, 1);
    pixelCheck("t3_attr8", 260, 0, 0);
    applyStimulus("t3_l11", 11, 36);
    checkOutput("t3_ovf_l11", 32'(overflow), 32'd1);
    applyStimulus("t3_l0", 0, 130);
    checkOutput("t3_ovf_l0", 32'(overflow), 32'd0);
    applyStimulus("t3_again", 10, 36);
    checkOutput("t3_ovf_again", 32'(overflow), 32'd1);

    $display("[TB] reset during attribute check");
    startEval(10);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_mid_done", 32'(evalDone), 32'd0);
    checkOutput("rst_mid_addr", 32'(attrAddr), 32'd0);
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (evalDone === 1'b1) doneSeen++;
    end
    checkOutput("rst_mid_nodone", 32'(doneSeen), 32'd0);
    applyStimulus("rst_after", 50, 130);
    pixelCheck("rst_after_px", 100, 0, 0);

    $display("[TB] overlapping sprites 3 and 5");
    clearAttrs();
    attrMem[3] = mkAttr(20, 40, 3, 1, 0);
    attrMem[5] = mkAttr(20, 40, 4, 6, 0);
    patMem[48] = 32'h2000_0000;
    patMem[64] = 32'hB000_0000;
    applyStimulus("t4", 20, 134);
    pixelCheck("t4_x40", 40, 5'b110_10, 1);
    pixelCheck("t4_x41", 41, 5'b001_10, 1);

    $display("[TB] hflip attribute");
    clearAttrs();
    attrMem[0] = mkAttr(30, 0, 5, 3, 1);
    patMem[80] = 32'hC000_0000;
    applyStimulus("t5", 30, 132);
`ifdef SPRITE_LINE_HFLIP_EN
    pixelCheck("t5_x15", 15, 5'b011_11, 1);
    pixelCheck("t5_x0", 0, 0, 0);
`else
    pixelCheck("t5_x0", 0, 5'b011_11, 1);
    pixelCheck("t5_x15", 15, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
